mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 52 +++++
 rtl/beat_timer.sv | 54 +++++
 rtl/mem_responder.sv | 172 +++++++++++++++++
 tb/tb_mem_responder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder and the CPU control unit:
// FSM states, request classes, opcode constants and request prioritisation.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_e;

    typedef enum logic [2:0] {
        REQ_NONE,
        REQ_FETCH,
        REQ_READ,
        REQ_WRITE,
        REQ_PUSH,
        REQ_POP,
        REQ_CONFLICT
    } req_e;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_PUSH  = 4'h3;
    localparam logic [3:0] OP_POP   = 4'h4;
    localparam logic [3:0] OP_JUMP  = 4'h5;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // Only the highest-priority class present is served; push+pop together is a protocol error.
    function automatic req_e classifyReq(input logic fetch, input logic read, input logic write,
                                         input logic push, input logic pop);
        if (fetch)
            return REQ_FETCH;
        else if (read)
            return REQ_READ;
        else if (write)
            return REQ_WRITE;
        else if (push && pop)
            return REQ_CONFLICT;
        else if (push)
            return REQ_PUSH;
        else if (pop)
            return REQ_POP;
        else
            return REQ_NONE;
    endfunction

    function automatic logic [1:0] beatsFor(input req_e cls);
        return (cls == REQ_FETCH) ? 2'd3 : 2'd1;
    endfunction

endpackage

// File: rtl/beat_timer.sv
// Sequences up to three RAM beats of WAIT+1 cycles each, flagging the last
// cycle of every beat and the last cycle of the final beat.
module beat_timer
    import mem_pkg::*;
#(
    parameter int WAIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [1:0] beats_i,
    output logic       last_o,
    output logic       final_o,
    output logic [1:0] beat_o
);

    localparam int WW = (WAIT < 1) ? 1 : $clog2(WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(WAIT);

    logic          busy_q;
    logic [WW-1:0] waitCnt_q;
    logic [1:0]    beatCnt_q;
    logic [1:0]    lastBeat_q;

    // A start request always restarts the sequence from beat 0, cycle 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= 1'b0;
            waitCnt_q  <= '0;
            beatCnt_q  <= '0;
            lastBeat_q <= '0;
        end else if (start_i) begin
            busy_q     <= 1'b1;
            waitCnt_q  <= '0;
            beatCnt_q  <= '0;
            lastBeat_q <= beats_i - 2'd1;
        end else if (busy_q) begin
            if (waitCnt_q == WAIT_MAX) begin
                waitCnt_q <= '0;
                if (beatCnt_q == lastBeat_q)
                    busy_q <= 1'b0;
                else
                    beatCnt_q <= beatCnt_q + 2'd1;
            end else begin
                waitCnt_q <= waitCnt_q + WW'(1);
            end
        end
    end

    assign last_o  = busy_q && (waitCnt_q == WAIT_MAX);
    assign final_o = last_o && (beatCnt_q == lastBeat_q);
    assign beat_o  = beatCnt_q;

endmodule

// File: rtl/mem_responder.sv
// Serves CPU fetch/read/write/stack requests against a single-port RAM with
// one cycle of read latency, stalling the CPU until each request completes.
module mem_responder
    import mem_pkg::*;
#(
    parameter int            DW       = 16,
    parameter int            AW       = 8,
    parameter int            WAIT     = 1,
    parameter logic [AW-1:0] SP_TOP   = {AW{1'b1}},
    parameter logic [AW-1:0] SP_LIMIT = {AW{1'b1}} - AW'(31)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem1RE,
    input  logic          mem2RE,
    input  logic          mem3RE,
    input  logic          mem4RE,
    input  logic          memWE,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] pc,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          stall,
    output logic [DW-1:0] instr0,
    output logic [DW-1:0] instr1,
    output logic [DW-1:0] instr2,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] sp,
    output logic          err,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    state_e        state_q;
    req_e          cls_q;
    logic [AW-1:0] sp_q;
    logic          err_q;
    logic [DW-1:0] instr0_q;
    logic [DW-1:0] instr1_q;
    logic [DW-1:0] instr2_q;
    logic [DW-1:0] rdata_q;
    logic [AW-1:0] ramAddr_q;
    logic          ramWe_q;
    logic [DW-1:0] ramWdata_q;

    req_e       reqClass;
    logic       anyReq;
    logic       rejectReq;
    logic       timerStart;
    logic       beatLast;
    logic       beatFinal;
    logic [1:0] beatIdx;

    assign reqClass = classifyReq(mem1RE | mem2RE | mem3RE, mem4RE, memWE, push, pop);
    assign anyReq   = (reqClass != REQ_NONE);

    // Stack overflow/underflow and push+pop conflicts finish immediately without touching RAM.
    assign rejectReq = (reqClass == REQ_CONFLICT)
                    || ((reqClass == REQ_PUSH) && (sp_q < SP_LIMIT))
                    || ((reqClass == REQ_POP) && (sp_q == SP_TOP));

    assign timerStart = (state_q == ST_IDLE) && anyReq && !rejectReq;

    beat_timer #(
        .WAIT(WAIT)
    ) u_beat_timer (
        .clk    (clk),
        .rst    (rst),
        .start_i(timerStart),
        .beats_i(beatsFor(reqClass)),
        .last_o (beatLast),
        .final_o(beatFinal),
        .beat_o (beatIdx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cls_q      <= REQ_NONE;
            sp_q       <= SP_TOP;
            err_q      <= 1'b0;
            instr0_q   <= '0;
            instr1_q   <= '0;
            instr2_q   <= '0;
            rdata_q    <= '0;
            ramAddr_q  <= '0;
            ramWe_q    <= 1'b0;
            ramWdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ramWe_q <= 1'b0;
                    if (anyReq) begin
                        if (rejectReq) begin
                            err_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            cls_q   <= reqClass;
                            state_q <= ST_ACCESS;
                            case (reqClass)
                                REQ_FETCH: ramAddr_q <= pc;
                                REQ_READ:  ramAddr_q <= addr;
                                REQ_WRITE: begin
                                    ramAddr_q  <= addr;
                                    ramWe_q    <= 1'b1;
                                    ramWdata_q <= wdata;
                                end
                                REQ_PUSH: begin
                                    ramAddr_q  <= sp_q;
                                    ramWe_q    <= 1'b1;
                                    ramWdata_q <= wdata;
                                end
                                REQ_POP: begin
                                    sp_q      <= sp_q + AW'(1);
                                    ramAddr_q <= sp_q + AW'(1);
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                // The RAM returns data one cycle after the address, so the last beat cycle sees it.
                ST_ACCESS: begin
                    ramWe_q <= 1'b0;
                    if (beatLast) begin
                        case (cls_q)
                            REQ_FETCH: begin
                                case (beatIdx)
                                    2'd0:    instr0_q <= ram_rdata;
                                    2'd1:    instr1_q <= ram_rdata;
                                    default: instr2_q <= ram_rdata;
                                endcase
                                if (!beatFinal)
                                    ramAddr_q <= ramAddr_q + AW'(1);
                            end
                            REQ_READ, REQ_POP: rdata_q <= ram_rdata;
                            default: ;
                        endcase
                        if (beatFinal) begin
                            state_q <= ST_DONE;
                            if (cls_q == REQ_PUSH)
                                sp_q <= sp_q - AW'(1);
                        end
                    end
                end

                ST_DONE: begin
                    ramWe_q <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stall     = anyReq && (state_q != ST_DONE);
    assign instr0    = instr0_q;
    assign instr1    = instr1_q;
    assign instr2    = instr2_q;
    assign rdata     = rdata_q;
    assign sp        = sp_q;
    assign err       = err_q;
    assign ram_addr  = ramAddr_q;
    assign ram_we    = ramWe_q;
    assign ram_wdata = ramWdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder with a behavioural
// one-cycle-latency RAM attached, WAIT=1.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem1RE = 1'b0, mem2RE = 1'b0, mem3RE = 1'b0, mem4RE = 1'b0;
    logic        memWE = 1'b0, push = 1'b0, pop = 1'b0;
    logic [7:0]  pc = '0, addr = '0;
    logic [15:0] wdata = '0;
    logic        stall, err, ram_we;
    logic [15:0] instr0, instr1, instr2, rdata, ram_wdata, ram_rdata;
    logic [7:0]  sp, ram_addr;

    logic        loadRam = 1'b1;
    logic [15:0] ram [256];

    int totalChecks  = 0;
    int passedChecks = 0;

    mem_responder #(
        .DW  (16),
        .AW  (8),
        .WAIT(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem1RE   (mem1RE),
        .mem2RE   (mem2RE),
        .mem3RE   (mem3RE),
        .mem4RE   (mem4RE),
        .memWE    (memWE),
        .push     (push),
        .pop      (pop),
        .pc       (pc),
        .addr     (addr),
        .wdata    (wdata),
        .stall    (stall),
        .instr0   (instr0),
        .instr1   (instr1),
        .instr2   (instr2),
        .rdata    (rdata),
        .sp       (sp),
        .err      (err),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] initWord(input int i);
        case (i)
            8'hFE:   return 16'hAAAA;
            8'hFF:   return 16'hBBBB;
            8'h00:   return 16'hCCCC;
            default: return 16'hD000 | 16'(i);
        endcase
    endfunction

    // Synchronous RAM: data appears one cycle after the address.
    always @(posedge clk) begin
        if (loadRam) begin
            for (int i = 0; i < 256; i++)
                ram[i] <= initWord(i);
        end else begin
            if (ram_we)
                ram[ram_addr] <= ram_wdata;
            ram_rdata <= ram[ram_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic f1, input logic rd, input logic wr, input logic ps,
                                 input logic pp, input logic [7:0] pcV, input logic [7:0] addrV,
                                 input logic [15:0] dataV);
        mem1RE = f1;
        mem2RE = 1'b0;
        mem3RE = 1'b0;
        mem4RE = rd;
        memWE  = wr;
        push   = ps;
        pop    = pp;
        pc     = pcV;
        addr   = addrV;
        wdata  = dataV;
    endtask

    task automatic clearReq();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        assert (observed === expected) begin
            passedChecks++;
        end else begin
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic resetDut();
        rst = 1'b1;
        clearReq();
        tick();
        rst = 1'b0;
    endtask

    task automatic pushOnce(input logic [15:0] dataV);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, dataV);
        tick();
        tick();
        tick();
        clearReq();
        tick();
    endtask

    logic [7:0] expAddr [6];

    initial begin
        // Reset values
        loadRam = 1'b1;
        resetDut();
        loadRam = 1'b0;
        checkOutput("rstSp", 32'(sp), 32'hFF);
        checkOutput("rstErr", 32'(err), 32'h0);
        checkOutput("rstInstr0", 32'(instr0), 32'h0);
        checkOutput("rstRdata", 32'(rdata), 32'h0);
        checkOutput("rstRamAddr", 32'(ram_addr), 32'h0);
        checkOutput("rstRamWe", 32'(ram_we), 32'h0);
        checkOutput("rstStall", 32'(stall), 32'h0);

        // Fetch with address wrap; pc change during ACCESS must be ignored
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFE, 8'h00, 16'h0000);
        #1;
        checkOutput("fetchStallT0", 32'(stall), 32'h1);
        expAddr = '{8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'h00, 8'h00};
        for (int k = 0; k < 6; k++) begin
            tick();
            pc = 8'h40;
            checkOutput("fetchStall", 32'(stall), 32'h1);
            checkOutput("fetchRamAddr", 32'(ram_addr), 32'(expAddr[k]));
            checkOutput("fetchRamWe", 32'(ram_we), 32'h0);
        end
        tick();
        checkOutput("fetchDoneStall", 32'(stall), 32'h0);
        checkOutput("fetchInstr0", 32'(instr0), 32'hAAAA);
        checkOutput("fetchInstr1", 32'(instr1), 32'hBBBB);
        checkOutput("fetchInstr2", 32'(instr2), 32'hCCCC);
        clearReq();
        tick();
        checkOutput("fetchIdleStall", 32'(stall), 32'h0);

        // Write then read back
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h10, 16'h1234);
        tick();
        wdata = 16'hFFFF;
        checkOutput("wrRamWe", 32'(ram_we), 32'h1);
        checkOutput("wrRamAddr", 32'(ram_addr), 32'h10);
        checkOutput("wrRamWdata", 32'(ram_wdata), 32'h1234);
        tick();
        checkOutput("wrRamWeOff", 32'(ram_we), 32'h0);
        checkOutput("wrStallT2", 32'(stall), 32'h1);
        tick();
        checkOutput("wrDoneStall", 32'(stall), 32'h0);
        clearReq();
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h10, 16'h0000);
        tick();
        tick();
        checkOutput("rdStallT2", 32'(stall), 32'h1);
        tick();
        checkOutput("rdDoneStall", 32'(stall), 32'h0);
        checkOutput("rdData", 32'(rdata), 32'h1234);
        clearReq();
        tick();

        // Fetch outranks write; RAM must never be written
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h30, 16'hDEAD);
        for (int k = 0; k < 6; k++) begin
            tick();
            checkOutput("prioRamWe", 32'(ram_we), 32'h0);
        end
        tick();
        checkOutput("prioDoneStall", 32'(stall), 32'h0);
        checkOutput("prioInstr0", 32'(instr0), 32'h1234);
        checkOutput("prioInstr1", 32'(instr1), 32'hD011);
        checkOutput("prioInstr2", 32'(instr2), 32'hD012);
        checkOutput("prioRdataHeld", 32'(rdata), 32'h1234);
        clearReq();
        tick();

        // Push then pop
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 16'h0055);
        tick();
        checkOutput("pushRamWe", 32'(ram_we), 32'h1);
        checkOutput("pushRamAddr", 32'(ram_addr), 32'hFF);
        checkOutput("pushSpHeld", 32'(sp), 32'hFF);
        tick();
        tick();
        checkOutput("pushDoneStall", 32'(stall), 32'h0);
        checkOutput("pushSp", 32'(sp), 32'hFE);
        clearReq();
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 16'h0000);
        tick();
        checkOutput("popSpEarly", 32'(sp), 32'hFF);
        checkOutput("popRamAddr", 32'(ram_addr), 32'hFF);
        tick();
        tick();
        checkOutput("popDoneStall", 32'(stall), 32'h0);
        checkOutput("popRdata", 32'(rdata), 32'h0055);
        checkOutput("popErr", 32'(err), 32'h0);
        clearReq();
        tick();

        // Push and pop together is a rejected no-op
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 16'h7777);
        #1;
        checkOutput("conflictStallT0", 32'(stall), 32'h1);
        tick();
        checkOutput("conflictDoneStall", 32'(stall), 32'h0);
        checkOutput("conflictErr", 32'(err), 32'h1);
        checkOutput("conflictSp", 32'(sp), 32'hFF);
        checkOutput("conflictRamWe", 32'(ram_we), 32'h0);
        clearReq();
        tick();

        // Pop on an empty stack
        resetDut();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 16'h0000);
        tick();
        checkOutput("underDoneStall", 32'(stall), 32'h0);
        checkOutput("underErr", 32'(err), 32'h1);
        checkOutput("underSp", 32'(sp), 32'hFF);
        checkOutput("underRamAddr", 32'(ram_addr), 32'h00);
        checkOutput("underRamWe", 32'(ram_we), 32'h0);
        clearReq();
        tick();

        // Fill the stack to its limit, then overflow
        resetDut();
        for (int k = 0; k < 32; k++)
            pushOnce(16'h0100 + 16'(k));
        checkOutput("fillSp", 32'(sp), 32'hDF);
        checkOutput("fillErr", 32'(err), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 16'h9999);
        tick();
        checkOutput("overDoneStall", 32'(stall), 32'h0);
        checkOutput("overErr", 32'(err), 32'h1);
        checkOutput("overSp", 32'(sp), 32'hDF);
        checkOutput("overRamWe", 32'(ram_we), 32'h0);
        clearReq();
        tick();

        // Reset during the second fetch beat
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00, 16'h0000);
        tick();
        tick();
        tick();
        checkOutput("abortPreInstr0", 32'(instr0), 32'hD020);
        checkOutput("abortPreRamAddr", 32'(ram_addr), 32'h21);
        rst = 1'b1;
        tick();
        checkOutput("abortInstr0", 32'(instr0), 32'h0);
        checkOutput("abortRamAddr", 32'(ram_addr), 32'h0);
        checkOutput("abortRamWe", 32'(ram_we), 32'h0);
        checkOutput("abortSp", 32'(sp), 32'hFF);
        checkOutput("abortStallReq", 32'(stall), 32'h1);
        clearReq();
        #1;
        checkOutput("abortStallIdle", 32'(stall), 32'h0);
        rst = 1'b0;
        tick();
        checkOutput("abortQuietAddr", 32'(ram_addr), 32'h0);
        checkOutput("abortQuietStall", 32'(stall), 32'h0);

        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule
